mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_lane_merge.sv | 46 ++++
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder and its lane logic.
package mem_pkg;

  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_CYCLES = 1;

  // Responder FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Access size encoding as seen on the Size port
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  // True when the size/alignment combination is illegal (reserved size included)
  function automatic logic bad_align(input size_t size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Little-endian byte-lane merge (for writes) and extract (for reads).
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_din,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [4:0] w_bit_ofs;

  assign w_bit_ofs = {i_addr_lo, 3'b000};

  // Replace only the addressed lanes; pull the addressed lanes down to bit 0
  always_comb begin
    o_merged = i_old;
    o_rdata  = 32'd0;
    case (size_t'(i_size))
      SZ_WORD: begin
        o_merged = i_din;
        o_rdata  = i_old;
      end
      SZ_BYTE: begin
        o_merged[w_bit_ofs +: 8] = i_din[7:0];
        o_rdata                  = {24'd0, i_old[w_bit_ofs +: 8]};
      end
      SZ_HALF: begin
        if (i_addr_lo[1]) begin
          o_merged[31:16] = i_din[15:0];
          o_rdata         = {16'd0, i_old[31:16]};
        end else begin
          o_merged[15:0] = i_din[15:0];
          o_rdata        = {16'd0, i_old[15:0]};
        end
      end
      default: begin
        o_merged = i_old;
        o_rdata  = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Word-organised memory slave with programmable wait states and
// byte/halfword/word accesses. One access is in flight at a time.
// Handshake: an access is accepted on a rising edge where Req=1 in IDLE;
// Ready pulses for exactly one cycle when it completes, and Dataout/Err are
// meaningful only in that cycle. Inputs are ignored while Busy=1.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Ready,
  output logic        Busy,
  output logic        Err,
  output logic [1:0]  o_dbg_state
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W   = DEPTH;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [1:0]  r_size;
  logic        r_wr;
  logic [31:0] r_dout;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic [31:0] w_addr;
  logic [31:0] w_din;
  logic [1:0]  w_size;
  logic        w_wr;
  logic        w_err;
  logic        w_enter_resp;
  logic [AW-1:0] w_idx;
  logic [31:0] w_old;
  logic [31:0] w_merged;
  logic [31:0] w_rdata;

  // In IDLE the access comes straight from the ports, so a zero-wait access
  // can complete on its acceptance edge; otherwise use the latched copy.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_addr = Address;
      w_din  = Datain;
      w_size = Size;
      w_wr   = Wr;
    end else begin
      w_addr = r_addr;
      w_din  = r_din;
      w_size = r_size;
      w_wr   = r_wr;
    end
  end

  assign w_err = bad_align(size_t'(w_size), w_addr[1:0]) ||
                 ({2'b00, w_addr[31:2]} >= DEPTH_W);
  assign w_idx = w_addr[AW+1:2];
  assign w_old = r_mem[w_idx];

  mem_lane_merge u_lane (
    .i_old     (w_old),
    .i_din     (w_din),
    .i_size    (w_size),
    .i_addr_lo (w_addr[1:0]),
    .o_merged  (w_merged),
    .o_rdata   (w_rdata)
  );

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Req) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == WAIT_LAST) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);

  // State, wait counter, request latch and response capture
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_size  <= '0;
      r_wr    <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && Req) begin
        r_addr <= Address;
        r_din  <= Datain;
        r_size <= Size;
        r_wr   <= Wr;
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt + 4'd1;
      else                   r_cnt <= '0;
      // Read data is taken from the pre-write word on the same edge the write lands
      if (w_enter_resp) begin
        r_err  <= w_err;
        r_dout <= (w_err || w_wr) ? 32'd0 : w_rdata;
      end
    end
  end

  // Storage: cleared by reset, written on the edge that enters RESP
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enter_resp && w_wr && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign Ready       = (r_state == S_RESP);
  assign Busy        = (r_state != S_IDLE);
  assign Dataout     = Ready ? r_dout : 32'd0;
  assign Err         = Ready & r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: table of single accesses on a 2-wait-state instance,
// reset-abort sequence, and back-to-back accesses on a zero-wait instance.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, din, dout;
  logic        ready, busy, err;
  logic [1:0]  dbg;

  logic        req0, wr0;
  logic [1:0]  size0;
  logic [31:0] addr0, din0, dout0;
  logic        ready0, busy0, err0;
  logic [1:0]  dbg0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_err;
    logic        chk_dout;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t ops0[$];

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .Clk(clk), .Reset(rst_n), .Req(req), .Wr(wr), .Size(size),
    .Address(addr), .Datain(din), .Dataout(dout), .Ready(ready),
    .Busy(busy), .Err(err), .o_dbg_state(dbg)
  );

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .Clk(clk), .Reset(rst_n), .Req(req0), .Wr(wr0), .Size(size0),
    .Address(addr0), .Datain(din0), .Dataout(dout0), .Ready(ready0),
    .Busy(busy0), .Err(err0), .o_dbg_state(dbg0)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] ed, input logic ee,
                              input logic cd, input string nm);
    vec_t v;
    v.wr = w; v.sz = s; v.addr = a; v.din = d;
    v.exp_dout = ed; v.exp_err = ee; v.chk_dout = cd; v.name = nm;
    return v;
  endfunction

  // Driver: one access on the 2-wait instance; returns response and latency
  task automatic do_acc(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] o_d,
                        output logic o_e, output int lat);
    logic quiet_ok;
    @(negedge clk);
    req = 1'b1; wr = w; size = s; addr = a; din = d;
    @(posedge clk);
    #1;
    // Scramble the bus after acceptance: only the latched copy may matter
    req = 1'b0; wr = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
    addr = $urandom; din = $urandom;
    lat = 0; quiet_ok = 1'b1; o_d = 32'd0; o_e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n; o_d = dout; o_e = err;
        break;
      end
      if (dout !== 32'd0 || err !== 1'b0 || busy !== 1'b1) quiet_ok = 1'b0;
    end
    check("outputs_quiet_before_ready", 32'(quiet_ok), 32'd1);
  endtask

  initial begin
    logic [31:0] r_d;
    logic        r_e;
    int          lat;
    logic        no_ready;

    req = 0; wr = 0; size = 0; addr = 0; din = 0;
    req0 = 0; wr0 = 0; size0 = 0; addr0 = 0; din0 = 0;

    // Reset block
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_err",   32'(err),   32'd0);
    check("reset_dout",  dout,       32'd0);
    check("reset_state", 32'(dbg),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of accesses, applied in order (state carries over between rows)
    vecs.push_back(mk(1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 0, 0, "w_word_10"));
    vecs.push_back(mk(0, 2'b00, 32'h10, 0, 32'hDEADBEEF, 0, 1, "r_word_10"));
    vecs.push_back(mk(1, 2'b00, 32'h10, 32'h11223344, 0, 0, 0, "w_word_10b"));
    vecs.push_back(mk(1, 2'b01, 32'h11, 32'h000000AA, 0, 0, 0, "w_byte_11"));
    vecs.push_back(mk(0, 2'b00, 32'h10, 0, 32'h1122AA44, 0, 1, "r_word_after_byte"));
    vecs.push_back(mk(0, 2'b01, 32'h11, 0, 32'h000000AA, 0, 1, "r_byte_11"));
    vecs.push_back(mk(0, 2'b01, 32'h13, 0, 32'h00000011, 0, 1, "r_byte_13"));
    vecs.push_back(mk(0, 2'b10, 32'h12, 0, 32'h00001122, 0, 1, "r_half_12"));
    vecs.push_back(mk(0, 2'b10, 32'h10, 0, 32'h0000AA44, 0, 1, "r_half_10"));
    vecs.push_back(mk(1, 2'b10, 32'h12, 32'hABCD5678, 0, 0, 0, "w_half_12"));
    vecs.push_back(mk(0, 2'b00, 32'h10, 0, 32'h5678AA44, 0, 1, "r_word_after_half"));
    vecs.push_back(mk(1, 2'b10, 32'h13, 32'h0000FFFF, 0, 1, 1, "w_half_misaligned"));
    vecs.push_back(mk(0, 2'b00, 32'h10, 0, 32'h5678AA44, 0, 1, "r_word_unchanged"));
    vecs.push_back(mk(0, 2'b00, 32'h102, 0, 0, 1, 1, "r_word_misaligned"));
    vecs.push_back(mk(1, 2'b00, 32'h400, 32'h00000099, 0, 1, 1, "w_word_out_of_range"));
    vecs.push_back(mk(0, 2'b00, 32'h0, 0, 32'h0, 0, 1, "r_word_0_no_wrap"));
    vecs.push_back(mk(0, 2'b11, 32'h10, 0, 0, 1, 1, "r_reserved_size"));
    vecs.push_back(mk(1, 2'b01, 32'h3FF, 32'hFFFFFF77, 0, 0, 0, "w_byte_last"));
    vecs.push_back(mk(0, 2'b00, 32'h3FC, 0, 32'h77000000, 0, 1, "r_word_last"));
    vecs.push_back(mk(0, 2'b01, 32'h3FF, 0, 32'h00000077, 0, 1, "r_byte_last"));
    vecs.push_back(mk(0, 2'b00, 32'hFFFFFFFC, 0, 0, 1, 1, "r_word_huge_addr"));
    vecs.push_back(mk(1, 2'b00, 32'h14, 32'hCAFEF00D, 0, 0, 0, "w_word_14"));
    vecs.push_back(mk(0, 2'b10, 32'h16, 0, 32'h0000CAFE, 0, 1, "r_half_16"));
    vecs.push_back(mk(1, 2'b11, 32'h14, 32'h0, 0, 1, 1, "w_reserved_size"));
    vecs.push_back(mk(0, 2'b00, 32'h14, 0, 32'hCAFEF00D, 0, 1, "r_word_14_kept"));

    foreach (vecs[i]) begin
      do_acc(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].din, r_d, r_e, lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
      check({vecs[i].name, "_err"}, 32'(r_e), 32'(vecs[i].exp_err));
      if (vecs[i].chk_dout) check({vecs[i].name, "_dout"}, r_d, vecs[i].exp_dout);
      @(negedge clk);
      check({vecs[i].name, "_ready_one_cycle"}, 32'(ready), 32'd0);
    end

    // Reset asserted while a write sits in WAIT: abort, no Ready
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h0; din = 32'h55;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("abort_in_wait_state", 32'(dbg), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_now",  32'(busy),  32'd0);
    check("abort_ready_now", 32'(ready), 32'd0);
    check("abort_state_now", 32'(dbg),   32'd0);
    no_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ready !== 1'b0) no_ready = 1'b0;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ready !== 1'b0) no_ready = 1'b0;
    end
    check("abort_no_ready", 32'(no_ready), 32'd1);
    do_acc(1'b0, 2'b00, 32'h0, 32'h0, r_d, r_e, lat);
    check("abort_word0_dout", r_d, 32'd0);
    check("abort_word0_err",  32'(r_e), 32'd0);
    check("abort_word0_lat",  32'(lat), 32'd3);

    // Back-to-back accesses with Req held high on the zero-wait instance
    ops0.push_back(mk(1, 2'b00, 32'h20, 32'h11110001, 0, 0, 0, "b2b_w20"));
    ops0.push_back(mk(1, 2'b00, 32'h24, 32'h22228802, 0, 0, 0, "b2b_w24"));
    ops0.push_back(mk(1, 2'b00, 32'h28, 32'h33330003, 0, 0, 0, "b2b_w28"));
    ops0.push_back(mk(0, 2'b00, 32'h20, 0, 32'h11110001, 0, 1, "b2b_r20"));
    ops0.push_back(mk(0, 2'b00, 32'h24, 0, 32'h22228802, 0, 1, "b2b_r24"));
    ops0.push_back(mk(0, 2'b01, 32'h25, 0, 32'h00000088, 0, 1, "b2b_r25"));
    foreach (ops0[k]) if (!ops0[k].wr) exp_q.push_back(ops0[k].exp_dout);

    @(negedge clk);
    req0 = 1'b1; wr0 = ops0[0].wr; size0 = ops0[0].sz; addr0 = ops0[0].addr; din0 = ops0[0].din;
    foreach (ops0[k]) begin
      @(negedge clk);
      check({ops0[k].name, "_ready"}, 32'(ready0), 32'd1);
      check({ops0[k].name, "_err"},   32'(err0),   32'd0);
      if (!ops0[k].wr) begin
        if (exp_q.size() == 0) check({ops0[k].name, "_queue_empty"}, 32'd1, 32'd0);
        else check({ops0[k].name, "_dout"}, dout0, exp_q.pop_front());
      end
      // New request appears during RESP; it must wait for the IDLE edge
      if (k + 1 < ops0.size()) begin
        wr0 = ops0[k+1].wr; size0 = ops0[k+1].sz; addr0 = ops0[k+1].addr; din0 = ops0[k+1].din;
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      check({ops0[k].name, "_gap_ready"}, 32'(ready0), 32'd0);
      check({ops0[k].name, "_gap_busy"},  32'(busy0),  32'd0);
    end
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
